// File: rtl/acc_inval_queue.sv
// Line-aligned, coalescing invalidation queue between an accelerator
// and the core's invalidation port.
module acc_inval_queue #(
    parameter int Depth      = 4,
    parameter int AddrWidth  = 64,
    parameter int LineOffset = 4,
    parameter int CntWidth   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 acc_cons_en_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic [AddrWidth-1:0] inval_addr_o,
    output logic                 inval_valid_o,
    input  logic                 inval_ready_i,
    output logic [CntWidth-1:0]  dedup_cnt_o,
    output logic [CntWidth-1:0]  drop_cnt_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int OccW = PtrW + 1;

    logic [AddrWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [OccW-1:0]      occ_q, occ_d;
    logic [CntWidth-1:0]  dedup_q, dedup_d;
    logic [CntWidth-1:0]  drop_q, drop_d;

    logic [AddrWidth-1:0] line;
    logic                 pop, push, accept;
    logic                 hit, hit_any;

    assign line = {req_addr_i[AddrWidth-1:LineOffset], {LineOffset{1'b0}}};
    assign pop  = (occ_q != '0) && inval_ready_i;

    // hit_any ignores the popping head so req_ready_o never sees
    // inval_ready_i; a head-only match that pops then becomes a push,
    // which fits because the pop frees that very slot.
    always_comb begin
        hit_any = 1'b0;
        hit     = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            logic [PtrW-1:0] rel;
            rel = PtrW'(i) - rd_ptr_q;
            if (({1'b0, rel} < occ_q) && (mem_q[i] == line)) begin
                hit_any = 1'b1;
                if (!(pop && (PtrW'(i) == rd_ptr_q))) begin
                    hit = 1'b1;
                end
            end
        end
    end

    assign req_ready_o = !acc_cons_en_i || hit_any || (occ_q < OccW'(Depth));
    assign accept      = req_valid_i && req_ready_o;
    assign push        = accept && acc_cons_en_i && !hit;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        dedup_d  = dedup_q;
        drop_d   = drop_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
        if (accept && !acc_cons_en_i && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
        if (accept && acc_cons_en_i && hit && (dedup_q != '1)) begin
            dedup_d = dedup_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            dedup_q  <= '0;
            drop_q   <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            dedup_q  <= dedup_d;
            drop_q   <= drop_d;
            if (push) begin
                mem_q[wr_ptr_q] <= line;
            end
        end
    end

    assign inval_valid_o = (occ_q != '0);
    assign inval_addr_o  = mem_q[rd_ptr_q];
    assign dedup_cnt_o   = dedup_q;
    assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_acc_inval_queue.sv
// Scoreboard bench for acc_inval_queue: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_acc_inval_queue;

    localparam int Depth = 4;
    localparam int AW    = 64;
    localparam int LO    = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          en_i = 1'b1;
    logic [AW-1:0] req_addr_i = '0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] inval_addr_o;
    logic          inval_valid_o;
    logic          inval_ready_i = 1'b0;
    logic [CW-1:0] dedup_cnt_o;
    logic [CW-1:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] mdl[$];
    logic [AW-1:0] exp_q[$];
    int            m_dedup = 0;
    int            m_drop  = 0;

    always #5 clk = ~clk;

    acc_inval_queue #(
        .Depth(Depth), .AddrWidth(AW), .LineOffset(LO), .CntWidth(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .acc_cons_en_i(en_i),
        .req_addr_i(req_addr_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .inval_addr_o(inval_addr_o),
        .inval_valid_o(inval_valid_o),
        .inval_ready_i(inval_ready_i),
        .dedup_cnt_o(dedup_cnt_o),
        .drop_cnt_o(drop_cnt_o)
    );

    task automatic chk(input string name, input logic [AW-1:0] act,
                       input logic [AW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every handshake on the core side pops the scoreboard.
    always @(posedge clk) begin
        if (!rst_i && inval_valid_o && inval_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected actual=%0h required=none",
                         inval_addr_o);
            end else begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                if (inval_addr_o !== e) begin
                    errors++;
                    $display("FAIL pop_addr actual=%0h required=%0h",
                             inval_addr_o, e);
                end
            end
        end
    end

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return (a >> LO) << LO;
    endfunction

    // One clock of stimulus; the model decides what should happen.
    task automatic cycle(input bit r, input bit e, input bit v,
                         input logic [AW-1:0] a, input bit rd);
        logic [AW-1:0] ln;
        bit popm, any, dup, rdy;
        @(negedge clk);
        rst_i = r;
        en_i = e;
        req_valid_i = v;
        req_addr_i = a;
        inval_ready_i = rd;
        #1;
        ln = align(a);
        if (!r) begin
            popm = (mdl.size() != 0) && rd;
            any = 1'b0;
            dup = 1'b0;
            foreach (mdl[i]) begin
                if (mdl[i] == ln) begin
                    any = 1'b1;
                    if (!(popm && i == 0)) dup = 1'b1;
                end
            end
            rdy = !e || any || (mdl.size() < Depth);
            chk("req_ready", AW'(req_ready_o), AW'(rdy));
            if (popm) void'(mdl.pop_front());
            if (v && rdy) begin
                if (!e) begin
                    if (m_drop < CMAX) m_drop++;
                end else if (dup) begin
                    if (m_dedup < CMAX) m_dedup++;
                end else begin
                    mdl.push_back(ln);
                    exp_q.push_back(ln);
                end
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            mdl.delete();
            exp_q.delete();
            m_dedup = 0;
            m_drop = 0;
        end
        chk("inval_valid", AW'(inval_valid_o), AW'(mdl.size() != 0));
        if (mdl.size() != 0) chk("head_addr", inval_addr_o, mdl[0]);
        chk("dedup_cnt", AW'(dedup_cnt_o), AW'(m_dedup));
        chk("drop_cnt", AW'(drop_cnt_o), AW'(m_drop));
    endtask

    task automatic idle(input bit e, input bit rd);
        cycle(0, e, 0, '0, rd);
    endtask

    logic [AW-1:0] pool [8];

    initial begin
        cycle(1, 1, 0, '0, 0);
        cycle(1, 1, 0, '0, 0);
        chk("rst_addr", inval_addr_o, '0);
        idle(1, 0);

        // ordered enqueue then drain
        cycle(0, 1, 1, 64'h1000, 0);
        cycle(0, 1, 1, 64'h2004, 0);
        cycle(0, 1, 1, 64'h300F, 0);
        idle(1, 0);
        chk("stable_head", inval_addr_o, 64'h1000);
        repeat (4) idle(1, 1);

        // coalescing, including a match on the popping head
        cycle(0, 1, 1, 64'h1000, 0);
        cycle(0, 1, 1, 64'h1008, 0);
        cycle(0, 1, 1, 64'h1008, 1);
        chk("requeued", inval_addr_o, 64'h1000);
        repeat (2) idle(1, 1);

        // full queue, dedup on full, retry after pop
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 64'h4000 + 64'(i) * 64'h10, 0);
        cycle(0, 1, 1, 64'h5000, 0);
        cycle(0, 1, 1, 64'h4025, 0);
        cycle(0, 1, 1, 64'h5000, 1);
        cycle(0, 1, 1, 64'h5000, 0);
        repeat (5) idle(1, 1);

        // consistency disabled: drops, queued entries still drain
        cycle(0, 1, 1, 64'h6000, 0);
        cycle(0, 1, 1, 64'h7000, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 64'h8000 + 64'(i), 0);
        repeat (3) idle(0, 1);

        // streaming
        for (int i = 0; i < 20; i++) cycle(0, 1, 1, 64'h10000 + 64'(i) * 64'h40, 1);
        idle(1, 1);

        // reset with entries queued, then saturation
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 64'h9000 + 64'(i) * 64'h10, 0);
        cycle(1, 1, 0, '0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, 64'(i), 1);

        // random traffic over a small line pool to provoke duplicates
        for (int i = 0; i < 8; i++) pool[i] = {$urandom, $urandom};
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] a;
            bit r;
            a = pool[$urandom_range(7)] | AW'($urandom_range(15));
            if ($urandom_range(9) == 0) a = {$urandom, $urandom};
            r = ($urandom_range(299) == 0);
            cycle(r, $urandom_range(7) != 0, $urandom_range(3) != 0, a,
                  $urandom_range(2) == 0);
        end
        repeat (6) idle(1, 1);
        chk("drained", AW'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
